ltc2308_emulator: RTL and testbench

LTC2308_EMULATOR -- requirements
Module: ltc2308_emulator

---
 rtl/ltc2308_pkg.sv | 31 +++
 rtl/ltc2308_emulator_if.sv | 11 +
 rtl/sync_edge_det.sv | 31 +++
 rtl/ltc2308_emulator.sv | 143 ++++++++++++++
 tb/tb_ltc2308_emulator.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/ltc2308_pkg.sv
// Shared LTC2308 definitions: resolution, config word layout, FSM encoding, channel decode.
// Imported by both the emulator and the ADC master.
package ltc2308_pkg;

  localparam int ADC_RES  = 12;
  localparam int CFG_SIZE = 6;

  // Config word layout {S/D, O/S, S1, S0, UNI, SLP}
  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  localparam logic [CFG_SIZE-1:0] CFG_DEFAULT = 6'b100010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2,
    SLEEP = 2'd3
  } state_t;

  // sel = cfg[5:2] = {S/D, O/S, S1, S0}; result matches the master's channel encoding.
  function automatic logic [3:0] chan_decode(input logic [3:0] sel);
    if (sel[3]) chan_decode = {1'b0, sel[1], sel[0], sel[2]};
    else        chan_decode = {1'b1, sel[2:0]};
  endfunction

endpackage

// File: rtl/ltc2308_emulator_if.sv
// Serial pins between an LTC2308 master and the emulated converter.
// The master drives CONVST/SCK/SDI; the converter drives SDO.
interface ltc2308_emulator_if;
  logic CONVST;
  logic SCK;
  logic SDI;
  logic SDO;

  modport master (output CONVST, output SCK, output SDI, input SDO);
  modport slave  (input CONVST, input SCK, input SDI, output SDO);
endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous input with single-cycle rise/fall pulses.
// Level lags the pin by STAGES cycles; the pulses are aligned with the level change.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(din);
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/ltc2308_emulator.sv
// Behavioural LTC2308 ADC: captures sample_data on CONVST, shifts it out on SCK, takes config on SDI.
// SDO follows an SCK fall by SYNC_STAGES+1 cycles; the master paces everything, no backpressure.
module ltc2308_emulator
  import ltc2308_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CONV_TICKS  = 40
) (
  input  logic                clock,
  input  logic                reset,
  ltc2308_emulator_if.slave   spi,
  output logic [3:0]          channel,
  input  logic [ADC_RES-1:0]  sample_data,
  output logic                sample_tick,
  output logic                cfg_valid,
  output logic [CFG_SIZE-1:0] cfg_word,
  output logic                sleeping,
  output logic                convst_err
);

  localparam int CW = $clog2(CONV_TICKS + 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_TICKS - 1);
  localparam logic [3:0]    FALL_LAST = 4'(ADC_RES - 1);
  localparam logic [2:0]    RISE_LAST = 3'(CFG_SIZE - 1);
  localparam logic [2:0]    RISE_MAX  = 3'(CFG_SIZE);

  logic cv_rise, sck_rise, sck_fall, sdi_lvl;
  logic unused_cv_lvl, unused_cv_fall, unused_sck_lvl, unused_sdi_rise, unused_sdi_fall;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_convst (
    .clock(clock), .reset(reset), .din(spi.CONVST),
    .level(unused_cv_lvl), .rise(cv_rise), .fall(unused_cv_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clock(clock), .reset(reset), .din(spi.SCK),
    .level(unused_sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sdi (
    .clock(clock), .reset(reset), .din(spi.SDI),
    .level(sdi_lvl), .rise(unused_sdi_rise), .fall(unused_sdi_fall)
  );

  state_t               state, state_next;
  logic                 start_conv, conv_err_c;
  logic [CW-1:0]        conv_cnt;
  logic [ADC_RES-1:0]   shift_reg;
  logic [3:0]           fall_cnt;
  logic [2:0]           rise_cnt;
  logic [CFG_SIZE-2:0]  cfg_shift;
  logic [CFG_SIZE-1:0]  cfg_next;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_conv = 1'b0;
    conv_err_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (cv_rise) begin
          state_next = CONV;
          start_conv = 1'b1;
        end
      end
      CONV: begin
        conv_err_c = cv_rise;
        if (conv_cnt == CONV_LAST) state_next = SHIFT;
      end
      SHIFT: begin
        if (cv_rise) begin
          state_next = CONV;
          start_conv = 1'b1;
        end else if (sck_fall && fall_cnt == FALL_LAST) begin
          // SLP was latched by this very transfer, so it decides where we land.
          state_next = cfg_word[CFG_SLP] ? SLEEP : IDLE;
        end
      end
      SLEEP: begin
        if (cv_rise) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cfg_next = {cfg_shift, sdi_lvl};

  always_ff @(posedge clock) begin
    if (reset) begin
      conv_cnt    <= '0;
      shift_reg   <= '0;
      fall_cnt    <= '0;
      rise_cnt    <= '0;
      cfg_shift   <= '0;
      cfg_word    <= CFG_DEFAULT;
      sample_tick <= 1'b0;
      cfg_valid   <= 1'b0;
      convst_err  <= 1'b0;
    end else begin
      sample_tick <= start_conv;
      convst_err  <= conv_err_c;
      cfg_valid   <= 1'b0;

      if (cv_rise) begin
        fall_cnt  <= '0;
        rise_cnt  <= '0;
        cfg_shift <= '0;
      end

      if (start_conv) begin
        shift_reg <= sample_data;
        conv_cnt  <= '0;
      end else if (state == CONV) begin
        conv_cnt <= conv_cnt + 1'b1;
      end

      if (state == SHIFT && !cv_rise) begin
        if (sck_fall) begin
          shift_reg <= {shift_reg[ADC_RES-2:0], 1'b0};
          fall_cnt  <= fall_cnt + 1'b1;
        end
        // Only the first CFG_SIZE rises carry config; later bits are don't-care.
        if (sck_rise && rise_cnt < RISE_MAX) begin
          cfg_shift <= cfg_next[CFG_SIZE-2:0];
          rise_cnt  <= rise_cnt + 1'b1;
          if (rise_cnt == RISE_LAST) begin
            cfg_word  <= cfg_next;
            cfg_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign spi.SDO  = (state == SHIFT) ? shift_reg[ADC_RES-1] : 1'b0;
  assign sleeping = (state == SLEEP);
  assign channel  = chan_decode(cfg_word[CFG_SD:CFG_S0]);

endmodule

// File: tb/tb_ltc2308_emulator.sv
// Directed bench for ltc2308_emulator: 320MHz clock, 40MHz SCK (8 clocks/period), CONV_TICKS=40.
`timescale 1ns/1ps
module tb_ltc2308_emulator;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  channel;
  logic [11:0] sample_data = '0;
  logic        sample_tick, cfg_valid, sleeping, convst_err;
  logic [5:0]  cfg_word;
  logic [11:0] rd;

  int total = 0;
  int bad   = 0;
  int tick_cnt = 0, cfgv_cnt = 0, err_cnt = 0;

  ltc2308_emulator_if spi_if();

  ltc2308_emulator #(.SYNC_STAGES(2), .CONV_TICKS(40)) dut (
    .clock       (clock),
    .reset       (reset),
    .spi         (spi_if),
    .channel     (channel),
    .sample_data (sample_data),
    .sample_tick (sample_tick),
    .cfg_valid   (cfg_valid),
    .cfg_word    (cfg_word),
    .sleeping    (sleeping),
    .convst_err  (convst_err)
  );

  always #1.5625 clock = ~clock;

  always @(negedge clock) begin
    if (sample_tick) tick_cnt++;
    if (cfg_valid)   cfgv_cnt++;
    if (convst_err)  err_cnt++;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    @(negedge clock);
    tick_cnt = 0;
    cfgv_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic pulse_convst();
    @(negedge clock);
    spi_if.CONVST = 1'b1;
    repeat (4) @(negedge clock);
    spi_if.CONVST = 1'b0;
  endtask

  task automatic wait_conv();
    repeat (50) @(negedge clock);
  endtask

  // SDI changes at the start of the low phase, SDO is sampled just before each rise.
  task automatic spi_xfer(input logic [5:0] cfg, input int nbits, output logic [11:0] data);
    logic [5:0] c;
    c = cfg;
    data = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clock);
      spi_if.SDI = c[5];
      c = c << 1;
      repeat (3) @(negedge clock);
      data = {data[10:0], spi_if.SDO};
      spi_if.SCK = 1'b1;
      repeat (4) @(negedge clock);
      spi_if.SCK = 1'b0;
    end
    spi_if.SDI = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  initial begin
    spi_if.CONVST = 1'b0;
    spi_if.SCK    = 1'b0;
    spi_if.SDI    = 1'b0;
    repeat (5) @(negedge clock);

    check_eq("rst_sdo",      {15'd0, spi_if.SDO}, 16'h0000);
    check_eq("rst_cfg_word", {10'd0, cfg_word},   16'h0022);
    check_eq("rst_channel",  {12'd0, channel},    16'h0000);
    check_eq("rst_pulses",   {13'd0, sample_tick, cfg_valid, convst_err}, 16'h0000);
    check_eq("rst_sleeping", {15'd0, sleeping},   16'h0000);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // Basic readout
    sample_data = 12'hA5C;
    clear_counts();
    pulse_convst();
    wait_conv();
    spi_xfer(6'b100010, 12, rd);
    check_eq("basic_rd",   {4'd0, rd}, 16'h0A5C);
    check_eq("basic_tick", 16'(tick_cnt), 16'd1);
    check_eq("basic_sdo_after", {15'd0, spi_if.SDO}, 16'h0000);

    // Config pipelining
    sample_data = 12'h7E1;
    clear_counts();
    pulse_convst();
    wait_conv();
    spi_xfer(6'b110010, 12, rd);
    check_eq("pipe_n_rd",   {4'd0, rd}, 16'h07E1);
    check_eq("pipe_n_cfgv", 16'(cfgv_cnt), 16'd1);
    check_eq("pipe_n_cfg",  {10'd0, cfg_word}, 16'h0032);
    check_eq("pipe_n_chan", {12'd0, channel}, 16'd1);
    clear_counts();
    pulse_convst();
    check_eq("pipe_n1_chan_at_conv", {12'd0, channel}, 16'd1);
    wait_conv();
    spi_xfer(6'b100010, 12, rd);
    check_eq("pipe_n1_cfgv", 16'(cfgv_cnt), 16'd1);
    check_eq("pipe_n1_cfg",  {10'd0, cfg_word}, 16'h0022);
    check_eq("pipe_n1_chan", {12'd0, channel}, 16'd0);

    // Differential decode
    pulse_convst();
    wait_conv();
    spi_xfer(6'b010010, 12, rd);
    check_eq("diff_chan12", {12'd0, channel}, 16'd12);
    pulse_convst();
    wait_conv();
    spi_xfer(6'b001110, 12, rd);
    check_eq("diff_chan11", {12'd0, channel}, 16'd11);

    // Abort after 5 falls
    sample_data = 12'hFFF;
    pulse_convst();
    wait_conv();
    spi_xfer(6'b110010, 5, rd);
    sample_data = 12'h123;
    clear_counts();
    pulse_convst();
    wait_conv();
    check_eq("abort_cfgv", 16'(cfgv_cnt), 16'd0);
    check_eq("abort_cfg",  {10'd0, cfg_word}, 16'h000E);
    check_eq("abort_tick", 16'(tick_cnt), 16'd1);
    spi_xfer(6'b001110, 12, rd);
    check_eq("abort_rd", {4'd0, rd}, 16'h0123);

    // CONVST rise during CONV
    sample_data = 12'h3C7;
    clear_counts();
    pulse_convst();
    repeat (6) @(negedge clock);
    sample_data = 12'h0FF;
    pulse_convst();
    wait_conv();
    check_eq("err_pulses", 16'(err_cnt), 16'd1);
    check_eq("err_tick",   16'(tick_cnt), 16'd1);
    spi_xfer(6'b001110, 12, rd);
    check_eq("err_rd", {4'd0, rd}, 16'h03C7);

    // Sleep and wake
    sample_data = 12'h456;
    pulse_convst();
    wait_conv();
    spi_xfer(6'b100011, 12, rd);
    check_eq("sleep_rd",  {4'd0, rd}, 16'h0456);
    check_eq("sleep_on",  {15'd0, sleeping}, 16'd1);
    check_eq("sleep_sdo", {15'd0, spi_if.SDO}, 16'd0);
    clear_counts();
    pulse_convst();
    repeat (10) @(negedge clock);
    check_eq("wake_sleeping", {15'd0, sleeping}, 16'd0);
    check_eq("wake_no_tick",  16'(tick_cnt), 16'd0);

    // Reset mid-transfer after 7 falls
    sample_data = 12'hFFF;
    pulse_convst();
    wait_conv();
    spi_xfer(6'b110010, 7, rd);
    check_eq("prerst_cfg", {10'd0, cfg_word}, 16'h0032);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("midrst_sdo", {15'd0, spi_if.SDO}, 16'd0);
    check_eq("midrst_cfg", {10'd0, cfg_word}, 16'h0022);
    check_eq("midrst_chan", {12'd0, channel}, 16'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    sample_data = 12'h5A5;
    clear_counts();
    spi_xfer(6'b110010, 12, rd);
    check_eq("postrst_no_conv_rd", {4'd0, rd}, 16'h0000);
    check_eq("postrst_no_cfgv",    16'(cfgv_cnt), 16'd0);
    check_eq("postrst_no_tick",    16'(tick_cnt), 16'd0);
    pulse_convst();
    wait_conv();
    spi_xfer(6'b100010, 12, rd);
    check_eq("postrst_rd", {4'd0, rd}, 16'h05A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
